tiger_fetch_queue: RTL and testbench

//  Parametrised fetch-to-decode stage. Replaces the single instruction register with a

---
 rtl/tiger_fetch_queue.sv | 128 ++++++++++++
 tb/tb_tiger_fetch_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tiger_fetch_queue.sv
// Fetch-to-decode stage: a DEPTH-entry instruction/PC queue in front of the decode
// output register, absorbing memory returns while decode is stalled.
module tiger_fetch_queue #(
    parameter int DATA_W    = 32,
    parameter int PC_W      = 32,
    parameter int DEPTH     = 4,
    parameter int AF_MARGIN = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     clear,
    input  logic [DATA_W-1:0]        instr,
    input  logic [PC_W-1:0]          instrPC,
    input  logic                     instrValid,
    output logic [DATA_W-1:0]        instrDE,
    output logic [PC_W-1:0]          pcDE,
    output logic                     validDE,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almostFull,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_LEVEL = CNT_W'(DEPTH - AF_MARGIN);

    // Handshake: memory offers instr/instrPC when instrValid (no ready; excess is dropped
    // and flagged in overflow). Decode takes instrDE when validDE && !stall.
    logic [DATA_W-1:0] mem_instr_q [DEPTH];
    logic [PC_W-1:0]   mem_pc_q    [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] instr_de_q, instr_de_d;
    logic [PC_W-1:0]   pc_de_q, pc_de_d;
    logic              valid_de_q, valid_de_d;
    logic              overflow_q, overflow_d;

    logic advance, empty, full, pop, bypass, push_req, push;

    always_comb begin
        advance  = !stall || !valid_de_q;
        empty    = (count_q == '0);
        full     = (count_q == FULL_CNT);
        pop      = advance && !empty;
        bypass   = advance && empty && instrValid;
        push_req = instrValid && !bypass;
        // A full queue still accepts a write when the head leaves in the same cycle.
        push     = push_req && (!full || pop);

        instr_de_d = instr_de_q;
        pc_de_d    = pc_de_q;
        valid_de_d = valid_de_q;
        if (pop) begin
            instr_de_d = mem_instr_q[rd_ptr_q];
            pc_de_d    = mem_pc_q[rd_ptr_q];
            valid_de_d = 1'b1;
        end else if (bypass) begin
            instr_de_d = instr;
            pc_de_d    = instrPC;
            valid_de_d = 1'b1;
        end else if (advance) begin
            instr_de_d = '0;
            pc_de_d    = '0;
            valid_de_d = 1'b0;
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        overflow_d = overflow_q | (push_req && full && !pop);

        // Flush discards the incoming instruction and keeps the sticky overflow flag.
        if (clear) begin
            instr_de_d = '0;
            pc_de_d    = '0;
            valid_de_d = 1'b0;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            instr_de_q <= '0;
            pc_de_q    <= '0;
            valid_de_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            instr_de_q <= instr_de_d;
            pc_de_q    <= pc_de_d;
            valid_de_q <= valid_de_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !clear && push) begin
            mem_instr_q[wr_ptr_q] <= instr;
            mem_pc_q[wr_ptr_q]    <= instrPC;
        end
    end

    assign instrDE    = instr_de_q;
    assign pcDE       = pc_de_q;
    assign validDE    = valid_de_q;
    assign count      = count_q;
    assign almostFull = (count_q >= AF_LEVEL);
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_tiger_fetch_queue.sv
// Bench for tiger_fetch_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_tiger_fetch_queue;

    localparam int DATA_W    = 32;
    localparam int PC_W      = 32;
    localparam int DEPTH     = 4;
    localparam int AF_MARGIN = 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              stall = 1'b0;
    logic              clear = 1'b0;
    logic [DATA_W-1:0] instr = '0;
    logic [PC_W-1:0]   instrPC = '0;
    logic              instrValid = 1'b0;
    logic [DATA_W-1:0] instrDE;
    logic [PC_W-1:0]   pcDE;
    logic              validDE;
    logic [2:0]        count;
    logic              almostFull;
    logic              overflow;

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    tiger_fetch_queue #(
        .DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .clear(clear),
        .instr(instr), .instrPC(instrPC), .instrValid(instrValid),
        .instrDE(instrDE), .pcDE(pcDE), .validDE(validDE),
        .count(count), .almostFull(almostFull), .overflow(overflow)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [63:0]       exp_q[$];
    logic [DATA_W-1:0] m_instr = '0;
    logic [PC_W-1:0]   m_pc = '0;
    logic              m_valid = 1'b0;
    logic              m_ovf = 1'b0;
    logic              m_byp;

    always @(posedge clk) begin
        if (reset || clear) begin
            exp_q.delete();
            m_instr = '0;
            m_pc    = '0;
            m_valid = 1'b0;
            if (reset) m_ovf = 1'b0;
        end else begin
            m_byp = 1'b0;
            if (!stall || !m_valid) begin
                if (exp_q.size() > 0) begin
                    {m_pc, m_instr} = exp_q.pop_front();
                    m_valid = 1'b1;
                end else if (instrValid) begin
                    m_instr = instr;
                    m_pc    = instrPC;
                    m_valid = 1'b1;
                    m_byp   = 1'b1;
                end else begin
                    m_instr = '0;
                    m_pc    = '0;
                    m_valid = 1'b0;
                end
            end
            if (instrValid && !m_byp) begin
                if (exp_q.size() < DEPTH) exp_q.push_back({instrPC, instr});
                else m_ovf = 1'b1;
            end
        end
    end

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_instrDE", 64'(instrDE), 64'(m_instr));
            chk("model_pcDE", 64'(pcDE), 64'(m_pc));
            chk("model_validDE", 64'(validDE), 64'(m_valid));
            chk("model_count", 64'(count), 64'(exp_q.size()));
            chk("model_almostFull", 64'(almostFull), 64'(exp_q.size() >= DEPTH - AF_MARGIN));
            chk("model_overflow", 64'(overflow), 64'(m_ovf));
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input logic rst, input logic st, input logic cl, input logic v,
                       input logic [31:0] ins, input logic [31:0] pc);
        reset      = rst;
        stall      = st;
        clear      = cl;
        instrValid = v;
        instr      = ins;
        instrPC    = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic [31:0] ins, input logic [31:0] pc,
                           input logic v, input logic [2:0] cnt);
        chk({name, "_instrDE"}, 64'(instrDE), 64'(ins));
        chk({name, "_pcDE"}, 64'(pcDE), 64'(pc));
        chk({name, "_validDE"}, 64'(validDE), 64'(v));
        chk({name, "_count"}, 64'(count), 64'(cnt));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        chk_out("reset", 0, 0, 0, 0);
        chk("reset_overflow", 64'(overflow), 64'(0));

        // 1: bypass with one-cycle latency
        cyc(0, 0, 0, 1, 32'h2402000A, 32'h100);
        chk_out("t1", 32'h2402000A, 32'h100, 1, 0);

        // 2: stalled fill to full, almostFull from count 3
        cyc(0, 1, 0, 1, 32'hA, 32'h104);
        cyc(0, 1, 0, 1, 32'hB, 32'h108);
        chk("t2_af_at2", 64'(almostFull), 64'(0));
        cyc(0, 1, 0, 1, 32'hC, 32'h10C);
        chk("t2_af_at3", 64'(almostFull), 64'(1));
        cyc(0, 1, 0, 1, 32'hD, 32'h110);
        chk_out("t2_full", 32'h2402000A, 32'h100, 1, 4);

        // 3: full with pop+push is legal; full with stall drops and flags overflow
        cyc(0, 0, 0, 1, 32'hE, 32'h114);
        chk_out("t3_poppush", 32'hA, 32'h104, 1, 4);
        chk("t3_no_ovf", 64'(overflow), 64'(0));
        cyc(0, 1, 0, 1, 32'hF, 32'h118);
        chk_out("t3_drop", 32'hA, 32'h104, 1, 4);
        chk("t3_ovf", 64'(overflow), 64'(1));
        cyc(0, 0, 0, 0, 0, 0);
        chk_out("t2_drainB", 32'hB, 32'h108, 1, 3);
        cyc(0, 0, 0, 0, 0, 0);
        chk_out("t2_drainC", 32'hC, 32'h10C, 1, 2);
        cyc(0, 0, 0, 0, 0, 0);
        chk_out("t2_drainD", 32'hD, 32'h110, 1, 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk_out("t2_drainE", 32'hE, 32'h114, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk_out("t2_empty", 0, 0, 0, 0);

        // 4: clear with instrValid in a stalled count=3 state
        cyc(0, 0, 0, 1, 32'h10, 32'h200);
        cyc(0, 1, 0, 1, 32'h11, 32'h204);
        cyc(0, 1, 0, 1, 32'h12, 32'h208);
        cyc(0, 1, 0, 1, 32'h13, 32'h20C);
        chk("t4_count3", 64'(count), 64'(3));
        cyc(0, 1, 1, 1, 32'h14, 32'h210);
        chk_out("t4_clear", 0, 0, 0, 0);
        chk("t4_ovf_kept", 64'(overflow), 64'(1));
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk_out("t4_idle", 0, 0, 0, 0);

        // 5: interleaved traffic with random stall, then drain
        for (int i = 0; i < 24; i++) begin
            cyc(0, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)),
                32'h3000 + 32'(i), 32'h400 + 32'(i * 4));
        end
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0);
        chk_out("t5_drained", 0, 0, 0, 0);

        // 6: reset mid-stream with count=2 and overflow=1
        cyc(0, 0, 0, 1, 32'h50, 32'h500);
        cyc(0, 1, 0, 1, 32'h51, 32'h504);
        cyc(0, 1, 0, 1, 32'h52, 32'h508);
        chk("t6_count2", 64'(count), 64'(2));
        chk("t6_ovf_pre", 64'(overflow), 64'(1));
        cyc(1, 1, 0, 1, 32'h53, 32'h50C);
        chk_out("t6_reset", 0, 0, 0, 0);
        chk("t6_ovf_cleared", 64'(overflow), 64'(0));
        cyc(0, 0, 0, 1, 32'h2402000B, 32'h600);
        chk_out("t6_bypass", 32'h2402000B, 32'h600, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk_out("t6_end", 0, 0, 0, 0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
